instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller that sequences the 16-bit instruction decoder and the ALU datapath. It fetches from instruction memory over a req/ack handshake and presents each word with a one-cycle `inst_wr` strobe. It then launches the ALU, waits for completion, strobes register writeback and updates the PC, resolving NOP, jump, branch-if-zero and halt itself. Instruction fields: opcode [15:12], rD [11:9], flag [8], rA [7:5], rB [4:2], imm [7:0].

---
 rtl/instr_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute controller.
// Fetches 16-bit words over a req/ack handshake, strobes the decoder, launches the ALU,
// waits for completion, strobes writeback and advances the PC. NOP, reserved (0xE), jump,
// branch-if-zero and halt are resolved here without touching the ALU.
// Optional feature: define SEQ_WDOG_EN to add an ALU watchdog (WAIT -> ERR after
// WDOG_CYCLES cycles without alu_done). Without it, WAIT waits indefinitely and err is 0.
module instr_sequencer #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     inst,
    output logic            inst_wr,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic            alu_zero,
    output logic            reg_we,
    output logic            halted,
    output logic            err,
    output logic [15:0]     retire_cnt
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StWait   = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;
    localparam logic [2:0] StErr    = 3'd7;

    // Reject illegal configurations at elaboration time.
    if (PC_W < 8 || PC_W > 16) begin : g_bad_pc_w
        $error("instr_sequencer: PC_W must be in 8..16");
    end
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_wdog
        $error("instr_sequencer: WDOG_CYCLES must be in 1..65535");
    end

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     inst_q, inst_d;
    logic [15:0]     retire_q, retire_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] imm_ext;
    logic [2:0]      next_st;
    logic            retire;
    logic            wdog_expired;

    assign pc_inc  = pc_q + PC_W'(1);
    // Retirement target: keep going while run is high, otherwise park in IDLE.
    assign next_st = run ? StFetch : StIdle;

`ifdef SEQ_WDOG_EN
    localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_q, wdog_d;

    // Watchdog counter: cleared in EXEC (the only way into WAIT), counts WAIT cycles.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == StExec) begin
            wdog_d = '0;
        end else if (state_q == StWait) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // This WAIT cycle is the WDOG_CYCLES-th one without completion.
    assign wdog_expired = (wdog_q == WdogLast);
    assign err          = (state_q == StErr);
`else
    assign wdog_expired = 1'b0;
    assign err          = 1'b0;
`endif

    // Zero-extend the 8-bit immediate to the PC width.
    always_comb begin
        imm_ext      = '0;
        imm_ext[7:0] = inst_q[7:0];
    end

    // Next-state, PC, instruction latch and retirement decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        retire  = 1'b0;
        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    inst_d  = imem_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (inst_q[15:12])
                    4'h0, 4'hE: begin
                        pc_d    = pc_inc;
                        retire  = 1'b1;
                        state_d = next_st;
                    end
                    4'hC: begin
                        pc_d    = imm_ext;
                        retire  = 1'b1;
                        state_d = next_st;
                    end
                    4'hD: begin
                        pc_d    = alu_zero ? imm_ext : pc_inc;
                        retire  = 1'b1;
                        state_d = next_st;
                    end
                    4'hF: begin
                        state_d = StHalt;
                    end
                    default: begin
                        state_d = StExec;
                    end
                endcase
            end
            StExec: begin
                state_d = StWait;
            end
            StWait: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (alu_done) begin
                    state_d = StWb;
                end else if (wdog_expired) begin
                    state_d = StErr;
                end
            end
            StWb: begin
                pc_d    = pc_inc;
                retire  = 1'b1;
                state_d = next_st;
            end
            StHalt, StErr: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        retire_d = retire ? retire_q + 16'd1 : retire_q;
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            inst_q   <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            retire_q <= retire_d;
        end
    end

    // Moore strobes decoded from the state register.
    assign imem_req   = (state_q == StFetch);
    assign inst_wr    = (state_q == StDecode);
    assign alu_start  = (state_q == StExec);
    assign reg_we     = (state_q == StWb);
    assign halted     = (state_q == StHalt);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected fetch addresses, decoded
// words and writeback PCs; a negedge monitor pops and compares whenever the DUT strobes.
module tb_instr_sequencer;

    localparam int unsigned PC_W = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            run = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [15:0]     imem_data = 16'h0;
    logic [15:0]     inst;
    logic            inst_wr;
    logic            alu_start;
    logic            alu_done = 1'b0;
    logic            alu_zero = 1'b0;
    logic            reg_we;
    logic            halted;
    logic            err;
    logic [15:0]     retire_cnt;

    instr_sequencer #(
        .PC_W        (PC_W),
        .WDOG_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst       (inst),
        .inst_wr    (inst_wr),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_zero   (alu_zero),
        .reg_we     (reg_we),
        .halted     (halted),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_lat = 0;
    int          alu_lat = 3;
    bit          alu_auto = 1'b1;
    int          ack_cnt = 0;
    int          alu_cnt = 0;
    logic [31:0] q_fetch [$];
    logic [31:0] q_dec [$];
    logic [31:0] q_wb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: strobe with value 0x%0h, none expected", name, act);
    endtask

    // Memory model: ack ack_lat cycles into FETCH, driven well after the clock edge.
    always @(posedge clk) begin
        #2;
        if (imem_req) begin
            if (ack_cnt >= ack_lat) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                ack_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            ack_cnt  = 0;
        end
    end

    // ALU model: alu_done alu_lat cycles after alu_start, if enabled.
    always @(posedge clk) begin
        #2;
        if (alu_start) begin
            alu_cnt  = alu_lat;
            alu_done = 1'b0;
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            alu_done = alu_auto && (alu_cnt == 0);
        end else begin
            alu_done = 1'b0;
        end
    end

    // Monitor: compare every DUT strobe against the scoreboard queues.
    always @(negedge clk) begin
        if (reset) begin
            if (imem_req && imem_ack) begin
                if (q_fetch.size() == 0) unexpected("fetch", 32'(imem_addr));
                else check("fetch_addr", 32'(imem_addr), q_fetch.pop_front());
            end
            if (inst_wr) begin
                if (q_dec.size() == 0) unexpected("decode", 32'(inst));
                else check("decode_inst", 32'(inst), q_dec.pop_front());
            end
            if (reg_we) begin
                if (q_wb.size() == 0) unexpected("reg_we", 32'(imem_addr));
                else check("wb_pc", 32'(imem_addr), q_wb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_strobes"}, 32'({imem_req, inst_wr, alu_start, reg_we, halted, err}), 32'h0);
        check({tag, "_pc"}, 32'(imem_addr), 32'h0);
        check({tag, "_inst"}, 32'(inst), 32'h0);
        check({tag, "_retire"}, 32'(retire_cnt), 32'h0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_sb_drain"}, 32'(q_fetch.size() + q_dec.size() + q_wb.size()), 32'h0);
    endtask

    task automatic do_reset();
        run   = 1'b0;
        reset = 1'b0;
        tick(2);
        q_fetch.delete();
        q_dec.delete();
        q_wb.delete();
        reset = 1'b1;
        tick(1);
    endtask

    task automatic wait_halt(input int max, output int cycles);
        cycles = 0;
        while (!halted && cycles < max) begin
            tick(1);
            cycles++;
        end
        check("halt_reached", 32'(halted), 32'h1);
    endtask

    task automatic wait_alu_start(input int max);
        int i;
        i = 0;
        while (!alu_start && i < max) begin
            tick(1);
            i++;
        end
        check("alu_start_seen", 32'(alu_start), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;

        // Reset values, sampled while reset is held.
        run = 1'b0;
        reset = 1'b0;
        tick(2);
        check_reset_vals("reset");
        reset = 1'b1;
        tick(2);
        check("idle_no_req", 32'(imem_req), 32'h0);

        // ALU instruction then halt; 10 cycles from run to HALT with a 3-cycle ALU.
        do_reset();
        mem[0] = 16'h2345;
        mem[1] = 16'hF000;
        q_fetch.push_back(0); q_fetch.push_back(1);
        q_dec.push_back(16'h2345); q_dec.push_back(16'hF000);
        q_wb.push_back(0);
        run = 1'b1;
        wait_halt(40, cyc);
        check("alu_prog_cycles", 32'(cyc), 32'd10);
        check("alu_prog_pc", 32'(imem_addr), 32'h1);
        check("alu_prog_retire", 32'(retire_cnt), 32'h1);
        check_drained("alu_prog");

        // NOP, jump to 5, halt: fetch order 0,1,5; 2 cycles per non-ALU op.
        do_reset();
        mem[0] = 16'h0000;
        mem[1] = 16'hC005;
        mem[5] = 16'hF000;
        q_fetch.push_back(0); q_fetch.push_back(1); q_fetch.push_back(5);
        q_dec.push_back(16'h0000); q_dec.push_back(16'hC005); q_dec.push_back(16'hF000);
        run = 1'b1;
        wait_halt(40, cyc);
        check("jump_cycles", 32'(cyc), 32'd7);
        check("jump_pc", 32'(imem_addr), 32'h5);
        check("jump_retire", 32'(retire_cnt), 32'h2);
        check_drained("jump");

        // Branch taken.
        do_reset();
        alu_zero = 1'b1;
        mem[0] = 16'hD010;
        mem[16] = 16'hF000;
        q_fetch.push_back(0); q_fetch.push_back(16);
        q_dec.push_back(16'hD010); q_dec.push_back(16'hF000);
        run = 1'b1;
        wait_halt(40, cyc);
        check("bz_taken_pc", 32'(imem_addr), 32'h10);
        check("bz_taken_retire", 32'(retire_cnt), 32'h1);
        check_drained("bz_taken");

        // Branch not taken.
        do_reset();
        alu_zero = 1'b0;
        mem[1] = 16'hF000;
        q_fetch.push_back(0); q_fetch.push_back(1);
        q_dec.push_back(16'hD010); q_dec.push_back(16'hF000);
        run = 1'b1;
        wait_halt(40, cyc);
        check("bz_not_taken_pc", 32'(imem_addr), 32'h1);
        check_drained("bz_not_taken");

        // Halt at address 3, stays put, then async reset clears everything.
        do_reset();
        mem[0] = 16'h0000;
        mem[1] = 16'h0000;
        mem[2] = 16'hE123;
        mem[3] = 16'hF000;
        for (int a = 0; a < 4; a++) q_fetch.push_back(a);
        q_dec.push_back(16'h0000); q_dec.push_back(16'h0000);
        q_dec.push_back(16'hE123); q_dec.push_back(16'hF000);
        run = 1'b1;
        wait_halt(40, cyc);
        tick(3);
        check("halt_sticky", 32'(halted), 32'h1);
        check("halt_pc", 32'(imem_addr), 32'h3);
        check("halt_retire", 32'(retire_cnt), 32'h3);
        check_drained("halt");
        run = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("halt_async_rst");
        tick(1);
        reset = 1'b1;
        tick(2);
        check("post_rst_idle", 32'(imem_req), 32'h0);

        // Drop run during WAIT: instruction completes, then IDLE; resume at next PC.
        do_reset();
        mem[0] = 16'h1234;
        mem[1] = 16'hF000;
        q_fetch.push_back(0);
        q_dec.push_back(16'h1234);
        q_wb.push_back(0);
        run = 1'b1;
        wait_alu_start(20);
        tick(1);
        run = 1'b0;
        tick(6);
        check("stop_idle_req", 32'(imem_req), 32'h0);
        check("stop_pc", 32'(imem_addr), 32'h1);
        check("stop_retire", 32'(retire_cnt), 32'h1);
        check_drained("stop");
        q_fetch.push_back(1);
        q_dec.push_back(16'hF000);
        run = 1'b1;
        wait_halt(40, cyc);
        check("resume_pc", 32'(imem_addr), 32'h1);
        check_drained("resume");

        // PC wrap 0xFF -> 0 with 2-cycle fetches.
        do_reset();
        ack_lat = 1;
        mem[0] = 16'hC0FF;
        mem[255] = 16'hE000;
        q_fetch.push_back(0); q_fetch.push_back(255); q_fetch.push_back(0);
        q_dec.push_back(16'hC0FF); q_dec.push_back(16'hE000); q_dec.push_back(16'hF000);
        run = 1'b1;
        cyc = 0;
        while (imem_addr != 8'hFF && cyc < 20) begin
            tick(1);
            cyc++;
        end
        mem[0] = 16'hF000;
        wait_halt(40, cyc);
        check("wrap_pc", 32'(imem_addr), 32'h0);
        check("wrap_retire", 32'(retire_cnt), 32'h2);
        check_drained("wrap");
        ack_lat = 0;

        // Async reset in the middle of WAIT.
        do_reset();
        alu_auto = 1'b0;
        mem[0] = 16'h2000;
        q_fetch.push_back(0);
        q_dec.push_back(16'h2000);
        run = 1'b1;
        wait_alu_start(20);
        tick(1);
        run = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("wait_async_rst");
        check_drained("wait_rst");

`ifdef SEQ_WDOG_EN
        // Watchdog: 4 WAIT cycles without alu_done -> ERR, no writeback, state frozen.
        do_reset();
        q_fetch.push_back(0);
        q_dec.push_back(16'h2000);
        run = 1'b1;
        wait_alu_start(20);
        tick(4);
        check("wdog_err_early", 32'(err), 32'h0);
        tick(1);
        check("wdog_err", 32'(err), 32'h1);
        tick(3);
        check("wdog_err_sticky", 32'(err), 32'h1);
        check("wdog_pc", 32'(imem_addr), 32'h0);
        check("wdog_retire", 32'(retire_cnt), 32'h0);
        check_drained("wdog");
`else
        // Without the watchdog WAIT never times out.
        do_reset();
        q_fetch.push_back(0);
        q_dec.push_back(16'h2000);
        run = 1'b1;
        wait_alu_start(20);
        tick(12);
        check("no_wdog_err", 32'(err), 32'h0);
        check("no_wdog_still_wait", 32'({imem_req, alu_start, reg_we, halted}), 32'h0);
        check("no_wdog_retire", 32'(retire_cnt), 32'h0);
        check_drained("no_wdog");
`endif
        alu_auto = 1'b1;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
